// File: rtl/i_tree_pkg.sv
// Shared types and defaults for the isolation-tree anomaly detector front end.
package i_tree_pkg;

    localparam int unsigned SAMPLE_W_DEF = 8;
    localparam int unsigned WIN_LOG2_DEF = 3;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_t;

    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] mean;
        logic [SAMPLE_W_DEF-1:0] min_val;
        logic [SAMPLE_W_DEF-1:0] max_val;
        logic [SAMPLE_W_DEF-1:0] range_val;
    } feature_t;

endpackage

// File: rtl/serial_sample_rx.sv
// Oversampled serial frame receiver: 2-flop synchronizer, mid-bit sampling FSM,
// one-cycle sample_valid / frame_err strobes.
module serial_sample_rx
    import i_tree_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sensor_in,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                frame_err
);

    localparam int unsigned CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BIT_W = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SAMPLE_W - 1);

    logic [1:0]          sync_q;
    logic                s;
    rx_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    assign s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (!s) begin
                    state_d = StStart;
                    cnt_d   = HALF_LOAD;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    // A line back high at the start midpoint was only a glitch.
                    if (!s) begin
                        state_d = StData;
                        cnt_d   = FULL_LOAD;
                        bit_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    shift_d = {s, shift_q[SAMPLE_W-1:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    if (s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], sensor_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign frame_err    = err_q;

endmodule

// File: rtl/sensor_feature_frontend.sv
// Serial sensor front end: frame receiver plus a windowed mean/min/max/range
// accumulator feeding the isolation tree.
module sensor_feature_frontend
    import i_tree_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
    parameter int unsigned WIN_LOG2   = WIN_LOG2_DEF,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sensor_in,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                frame_err,
    output logic                feat_valid,
    output logic [SAMPLE_W-1:0] feat_mean,
    output logic [SAMPLE_W-1:0] feat_min,
    output logic [SAMPLE_W-1:0] feat_max,
    output logic [SAMPLE_W-1:0] feat_range
);

    localparam int unsigned SUM_W = SAMPLE_W + WIN_LOG2;

    serial_sample_rx #(
        .SAMPLE_W   (SAMPLE_W),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_in    (sensor_in),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .frame_err    (frame_err)
    );

    logic [SUM_W-1:0]    sum_q, sum_next;
    logic [SAMPLE_W-1:0] min_q, min_next;
    logic [SAMPLE_W-1:0] max_q, max_next;
    logic [WIN_LOG2-1:0] cnt_q;
    logic                feat_valid_q;
    logic [SAMPLE_W-1:0] mean_q, fmin_q, fmax_q, frange_q;

    always_comb begin
        sum_next = sum_q + SUM_W'(sample_data);
        min_next = (sample_data < min_q) ? sample_data : min_q;
        max_next = (sample_data > max_q) ? sample_data : max_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q        <= '0;
            min_q        <= '1;
            max_q        <= '0;
            cnt_q        <= '0;
            feat_valid_q <= 1'b0;
            mean_q       <= '0;
            fmin_q       <= '0;
            fmax_q       <= '0;
            frange_q     <= '0;
        end else begin
            feat_valid_q <= 1'b0;
            if (sample_valid) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    // Window-closing sample: publish features, re-arm the running stats.
                    mean_q       <= sum_next[SUM_W-1:WIN_LOG2];
                    fmin_q       <= min_next;
                    fmax_q       <= max_next;
                    frange_q     <= max_next - min_next;
                    feat_valid_q <= 1'b1;
                    sum_q        <= '0;
                    min_q        <= '1;
                    max_q        <= '0;
                end else begin
                    sum_q <= sum_next;
                    min_q <= min_next;
                    max_q <= max_next;
                end
            end
        end
    end

    assign feat_valid = feat_valid_q;
    assign feat_mean  = mean_q;
    assign feat_min   = fmin_q;
    assign feat_max   = fmax_q;
    assign feat_range = frange_q;

endmodule
